// File: rtl/asymm_delay_bank.sv
`default_nettype none
// ============================================================================
// Module   : asymm_delay_bank
// Brief    : Bank of independent level-delay channels with separate rise and
//            fall qualification delays. A level must persist for D+1 sampled
//            cycles before it reaches the output; shorter excursions are
//            dropped and reported with a one-cycle filt pulse.
// Revision : 1.0 - initial release
// ============================================================================
module asymm_delay_bank #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 4,
   parameter int RISE_RST = 4,
   parameter int FALL_RST = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [CNT_W-1:0]    cfg_rise_dly,
   input  logic [CNT_W-1:0]    cfg_fall_dly,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] filt
);

   localparam logic [CNT_W-1:0] c_RISE_RST = CNT_W'(RISE_RST);
   localparam logic [CNT_W-1:0] c_FALL_RST = CNT_W'(FALL_RST);
   localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

   // Encoding chosen so bit 1 marks "output high" and bit 0 marks "counting".
   typedef enum logic [1:0] {
      ST_LOW  = 2'b00,
      ST_RISE = 2'b01,
      ST_HIGH = 2'b10,
      ST_FALL = 2'b11
   } state_t;

   logic [CNT_W-1:0]    r_rise_dly;
   logic [CNT_W-1:0]    r_fall_dly;
   logic [CHANNELS-1:0] r_in_q;

   // Shared delay configuration; channels read the pre-edge value when loading.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rise_dly <= c_RISE_RST;
         r_fall_dly <= c_FALL_RST;
      end else if (cfg_we) begin
         r_rise_dly <= cfg_rise_dly;
         r_fall_dly <= cfg_fall_dly;
      end
   end

   // Input sampling stage; all channel decisions use this registered copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_q <= '0;
      end else begin
         r_in_q <= in;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_filt_nxt;
      logic             r_out;
      logic             r_busy;
      logic             r_filt;

      // Next-state, counter and cancel-pulse decode for one channel.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_filt_nxt  = 1'b0;
         case (r_state)
            ST_LOW: begin
               if (r_in_q[g]) begin
                  if (r_rise_dly == '0) begin
                     w_state_nxt = ST_HIGH;
                  end else begin
                     w_cnt_nxt   = r_rise_dly;
                     w_state_nxt = ST_RISE;
                  end
               end
            end
            ST_RISE: begin
               if (!r_in_q[g]) begin
                  w_state_nxt = ST_LOW;
                  w_filt_nxt  = 1'b1;
               end else if (r_cnt == c_ONE) begin
                  w_state_nxt = ST_HIGH;
               end else begin
                  w_cnt_nxt = r_cnt - c_ONE;
               end
            end
            ST_HIGH: begin
               if (!r_in_q[g]) begin
                  if (r_fall_dly == '0) begin
                     w_state_nxt = ST_LOW;
                  end else begin
                     w_cnt_nxt   = r_fall_dly;
                     w_state_nxt = ST_FALL;
                  end
               end
            end
            ST_FALL: begin
               if (r_in_q[g]) begin
                  w_state_nxt = ST_HIGH;
                  w_filt_nxt  = 1'b1;
               end else if (r_cnt == c_ONE) begin
                  w_state_nxt = ST_LOW;
               end else begin
                  w_cnt_nxt = r_cnt - c_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_LOW;
            end
         endcase
      end

      // State, counter and registered outputs derived from the next state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_filt  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL);
            r_busy  <= (w_state_nxt == ST_RISE) || (w_state_nxt == ST_FALL);
            r_filt  <= w_filt_nxt;
         end
      end

      assign out[g]  = r_out;
      assign busy[g] = r_busy;
      assign filt[g] = r_filt;
   end

endmodule
`default_nettype wire
